// File: rtl/otter_iobus_timer_gpio.sv
// OTTER IOBUS responder: LED register, synchronized switches and a prescaled down-counting timer.
// Optional switch-change interrupt enabled by defining SW_CHANGE_IRQ_EN.
module otter_iobus_timer_gpio #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter int          PRESCALE  = 10,
    parameter int          LED_W     = 16,
    parameter int          SW_W      = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [31:0]      IOBUS_ADDR,
    input  logic [31:0]      IOBUS_OUT,
    input  logic             IOBUS_WR,
    input  logic             IOBUS_RD,
    output logic [31:0]      IOBUS_IN,
    output logic [LED_W-1:0] LEDS,
    input  logic [SW_W-1:0]  SWITCHES,
    output logic             INTR
);

    localparam logic [2:0]  SEL_LEDS   = 3'd0;
    localparam logic [2:0]  SEL_SW     = 3'd1;
    localparam logic [2:0]  SEL_CTRL   = 3'd2;
    localparam logic [2:0]  SEL_LOAD   = 3'd3;
    localparam logic [2:0]  SEL_COUNT  = 3'd4;
    localparam logic [2:0]  SEL_STATUS = 3'd5;
    localparam logic [16:0] PRE_LAST   = 17'(PRESCALE - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [16:0]     pre;
    logic [31:0]     count;
    logic [31:0]     load;
    logic [LED_W-1:0] led_reg;
    logic [SW_W-1:0] sw_meta;
    logic [SW_W-1:0] sw_sync;
    logic            ctrl_auto;
    logic            ctrl_tie;
    logic            tpend;
    logic            spend;
    logic            sie;
    logic [31:0]     rd_mux;
    logic [31:0]     rdata_p1;

    logic            hit;
    logic [2:0]      sel;
    logic            wr_en;
    logic            wr_leds;
    logic            wr_ctrl;
    logic            wr_load;
    logic            wr_status;
    logic            tick;
    logic            expire;
    logic            unused_bits;

    // Byte lanes are irrelevant: every register is a full word.
    assign unused_bits = ^IOBUS_ADDR[1:0];

    assign hit       = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]) && (IOBUS_ADDR[4:0] < 5'h18);
    assign sel       = IOBUS_ADDR[4:2];
    assign wr_en     = IOBUS_WR && hit;
    assign wr_leds   = wr_en && (sel == SEL_LEDS);
    assign wr_ctrl   = wr_en && (sel == SEL_CTRL);
    assign wr_load   = wr_en && (sel == SEL_LOAD);
    assign wr_status = wr_en && (sel == SEL_STATUS);

    assign tick   = (state == RUN) && (pre == PRE_LAST);
    assign expire = tick && (count == 32'd0);

    // Timer FSM: prescaler, counter and run state; bus writes override tick updates.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            pre   <= '0;
            count <= '0;
            load  <= '0;
        end else begin
            if ((state == IDLE) || tick || wr_load)
                pre <= '0;
            else
                pre <= pre + 17'd1;

            if (wr_load) begin
                load  <= IOBUS_OUT;
                count <= IOBUS_OUT;
            end else if (tick) begin
                if (count != 32'd0)
                    count <= count - 32'd1;
                else if (ctrl_auto)
                    count <= load;
            end

            if (wr_ctrl)
                state <= IOBUS_OUT[0] ? RUN : IDLE;
            else if (expire && !ctrl_auto)
                state <= IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            led_reg   <= '0;
            ctrl_auto <= 1'b0;
            ctrl_tie  <= 1'b0;
            tpend     <= 1'b0;
            sw_meta   <= '0;
            sw_sync   <= '0;
        end else begin
            if (wr_leds)
                led_reg <= IOBUS_OUT[LED_W-1:0];
            if (wr_ctrl) begin
                ctrl_auto <= IOBUS_OUT[1];
                ctrl_tie  <= IOBUS_OUT[2];
            end
            // Hardware set wins over a same-edge write-1-to-clear.
            tpend   <= expire | (tpend & ~(wr_status & IOBUS_OUT[0]));
            sw_meta <= SWITCHES;
            sw_sync <= sw_meta;
        end
    end

`ifdef SW_CHANGE_IRQ_EN
    logic [SW_W-1:0] sw_prev;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sw_prev <= '0;
            spend   <= 1'b0;
            sie     <= 1'b0;
        end else begin
            sw_prev <= sw_sync;
            spend   <= (sw_sync != sw_prev) | (spend & ~(wr_status & IOBUS_OUT[1]));
            if (wr_ctrl)
                sie <= IOBUS_OUT[3];
        end
    end
`else
    assign spend = 1'b0;
    assign sie   = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_LEDS:   rd_mux = 32'(led_reg);
            SEL_SW:     rd_mux = 32'(sw_sync);
            SEL_CTRL:   rd_mux = {28'd0, sie, ctrl_tie, ctrl_auto, (state == RUN)};
            SEL_LOAD:   rd_mux = load;
            SEL_COUNT:  rd_mux = count;
            SEL_STATUS: rd_mux = {30'd0, spend, tpend};
            default:    rd_mux = '0;
        endcase
    end

    // Read data stage: non-zero only in the cycle after a hitting read, so it can be OR-combined.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            rdata_p1 <= '0;
        else
            rdata_p1 <= (IOBUS_RD && hit) ? rd_mux : 32'd0;
    end

    assign IOBUS_IN = rdata_p1;
    assign LEDS     = led_reg;
    assign INTR     = (tpend & ctrl_tie) | (spend & sie);

endmodule

// File: tb/tb_otter_iobus_timer_gpio.sv
// Scoreboard bench for otter_iobus_timer_gpio: reads push expected data, a monitor checks IOBUS_IN.
module tb_otter_iobus_timer_gpio;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [31:0] IOBUS_ADDR = '0;
    logic [31:0] IOBUS_OUT = '0;
    logic        IOBUS_WR = 1'b0;
    logic        IOBUS_RD = 1'b0;
    logic [31:0] IOBUS_IN;
    logic [15:0] LEDS;
    logic [15:0] SWITCHES = '0;
    logic        INTR;

    localparam logic [31:0] A_LEDS   = 32'h1100_0000;
    localparam logic [31:0] A_SW     = 32'h1100_0004;
    localparam logic [31:0] A_CTRL   = 32'h1100_0008;
    localparam logic [31:0] A_LOAD   = 32'h1100_000C;
    localparam logic [31:0] A_COUNT  = 32'h1100_0010;
    localparam logic [31:0] A_STATUS = 32'h1100_0014;
`ifdef SW_CHANGE_IRQ_EN
    localparam logic SWIRQ = 1'b1;
`else
    localparam logic SWIRQ = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic rd_seen = 1'b0;

    otter_iobus_timer_gpio dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_RD   (IOBUS_RD),
        .IOBUS_IN   (IOBUS_IN),
        .LEDS       (LEDS),
        .SWITCHES   (SWITCHES),
        .INTR       (INTR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: data is due the cycle after a read strobe, zero otherwise.
    always @(posedge CLK) rd_seen <= IOBUS_RD;

    always @(negedge CLK) begin
        exp_t e;
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_unexpected: got 0x%08h with no expected entry", IOBUS_IN);
            end else begin
                e = exp_q.pop_front();
                check(e.name, IOBUS_IN, e.val);
            end
        end else begin
            check("rd_idle_zero", IOBUS_IN, 32'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        IOBUS_WR   = 1'b1;
        step(1);
        IOBUS_WR   = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.val  = exp;
        exp_q.push_back(e);
        IOBUS_ADDR = addr;
        IOBUS_RD   = 1'b1;
        step(1);
        IOBUS_RD   = 1'b0;
    endtask

    task automatic bus_rw(input string name, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.val  = exp;
        exp_q.push_back(e);
        IOBUS_ADDR = addr;
        IOBUS_OUT  = data;
        IOBUS_RD   = 1'b1;
        IOBUS_WR   = 1'b1;
        step(1);
        IOBUS_RD   = 1'b0;
        IOBUS_WR   = 1'b0;
    endtask

    task automatic read_all_zero(input string tag);
        bus_read({tag, "_leds"},   A_LEDS,   32'd0);
        bus_read({tag, "_sw"},     A_SW,     32'd0);
        bus_read({tag, "_ctrl"},   A_CTRL,   32'd0);
        bus_read({tag, "_load"},   A_LOAD,   32'd0);
        bus_read({tag, "_count"},  A_COUNT,  32'd0);
        bus_read({tag, "_status"}, A_STATUS, 32'd0);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 RST_N = 1'b0;
        #1;
        check("rst_intr", 32'(INTR), 32'd0);
        check("rst_iobus_in", IOBUS_IN, 32'd0);
        check("rst_leds", 32'(LEDS), 32'd0);
        step(3);
        RST_N = 1'b1;
        read_all_zero("init");

        // LED register
        bus_write(A_LEDS, 32'h0000_A5A5);
        check("leds_after_wr", 32'(LEDS), 32'h0000_A5A5);
        bus_read("leds_rd", A_LEDS, 32'h0000_A5A5);
        step(1);
        bus_write(A_LEDS, 32'hFFFF_1234);
        check("leds_truncated", 32'(LEDS), 32'h0000_1234);
        bus_read("leds_rd_lowbits", 32'h1100_0003, 32'h0000_1234);

        // One-shot timer
        bus_write(A_LOAD, 32'd3);
        bus_read("load_rd", A_LOAD, 32'd3);
        bus_read("count_after_load", A_COUNT, 32'd3);
        bus_write(A_CTRL, 32'h5);
        step(4);
        bus_read("os_count3", A_COUNT, 32'd3);
        step(9);
        bus_read("os_count2", A_COUNT, 32'd2);
        step(9);
        bus_read("os_count1", A_COUNT, 32'd1);
        step(9);
        bus_read("os_count0", A_COUNT, 32'd0);
        bus_read("os_status_early", A_STATUS, 32'd0);
        step(3);
        check("os_intr_clk39", 32'(INTR), 32'd0);
        step(1);
        check("os_intr_clk40", 32'(INTR), 32'd1);
        bus_read("os_ctrl_en_cleared", A_CTRL, 32'h4);
        bus_read("os_status", A_STATUS, 32'h1);
        bus_read("os_count_held", A_COUNT, 32'd0);
        bus_write(A_STATUS, 32'h1);
        check("os_intr_w1c", 32'(INTR), 32'd0);

        // Auto-reload timer
        bus_write(A_LOAD, 32'd2);
        bus_write(A_CTRL, 32'h7);
        step(29);
        check("auto_intr_clk29", 32'(INTR), 32'd0);
        step(1);
        check("auto_intr_clk30", 32'(INTR), 32'd1);
        bus_write(A_STATUS, 32'h1);
        check("auto_w1c", 32'(INTR), 32'd0);
        step(28);
        bus_write(A_STATUS, 32'h1);
        check("auto_w1c_vs_expiry", 32'(INTR), 32'd1);
        bus_read("auto_status", A_STATUS, 32'h1);
        bus_read("auto_count_reload", A_COUNT, 32'd2);
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'h1);
        check("auto_stopped", 32'(INTR), 32'd0);

        // LOAD=0 with auto-reload expires on every tick
        bus_write(A_LOAD, 32'd0);
        bus_write(A_CTRL, 32'h7);
        step(9);
        check("zero_intr_clk9", 32'(INTR), 32'd0);
        step(1);
        check("zero_intr_clk10", 32'(INTR), 32'd1);
        bus_write(A_STATUS, 32'h1);
        check("zero_w1c", 32'(INTR), 32'd0);
        step(9);
        check("zero_intr_clk20", 32'(INTR), 32'd1);
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'h1);

        // Decode misses
        bus_read("miss_rd_0x18", 32'h1100_0018, 32'd0);
        bus_read("miss_rd_other", 32'h2000_0000, 32'd0);
        bus_write(32'h1100_0018, 32'hFFFF_FFFF);
        bus_write(32'h1100_001C, 32'hFFFF_FFFF);
        bus_write(32'h2000_0000, 32'hFFFF_FFFF);
        bus_write(32'h2000_000C, 32'hFFFF_FFFF);
        check("miss_leds", 32'(LEDS), 32'h0000_1234);
        bus_read("miss_leds_rd", A_LEDS, 32'h0000_1234);
        bus_read("miss_ctrl_rd", A_CTRL, 32'd0);
        bus_read("miss_load_rd", A_LOAD, 32'd0);
        bus_read("miss_status_rd", A_STATUS, 32'd0);

        // Simultaneous read and write returns the pre-write value
        bus_rw("rw_old_value", A_LEDS, 32'h0000_00FF, 32'h0000_1234);
        check("rw_leds", 32'(LEDS), 32'h0000_00FF);
        bus_read("rw_new_value", A_LEDS, 32'h0000_00FF);

        // Switch synchronizer and change interrupt
        bus_write(A_CTRL, 32'h8);
        bus_read("sie_rd", A_CTRL, SWIRQ ? 32'h8 : 32'h0);
        SWITCHES = 16'h0008;
        step(1);
        bus_read("sw_not_yet", A_SW, 32'd0);
        check("sw_intr_early", 32'(INTR), 32'd0);
        bus_read("sw_synced", A_SW, 32'h0000_0008);
        check("sw_intr", 32'(INTR), 32'(SWIRQ));
        bus_read("sw_status", A_STATUS, SWIRQ ? 32'h2 : 32'h0);
        SWITCHES = 16'h0000;
        step(3);
        bus_write(A_STATUS, 32'h2);
        check("sw_w1c", 32'(INTR), 32'd0);
        bus_write(A_CTRL, 32'h0);

        // Asynchronous reset mid-run with COUNT=5 and TPEND=1
        bus_write(A_LOAD, 32'd0);
        bus_write(A_CTRL, 32'h7);
        step(10);
        bus_write(A_LOAD, 32'd5);
        bus_write(A_CTRL, 32'h4);
        check("prerst_intr", 32'(INTR), 32'd1);
        bus_read("prerst_count", A_COUNT, 32'd5);
        bus_read("prerst_status", A_STATUS, 32'h1);
        step(1);
        #2 RST_N = 1'b0;
        #1;
        check("midrst_intr", 32'(INTR), 32'd0);
        check("midrst_iobus_in", IOBUS_IN, 32'd0);
        check("midrst_leds", 32'(LEDS), 32'd0);
        step(2);
        RST_N = 1'b1;
        read_all_zero("postrst");

        step(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
